// File: rtl/ddr_mem_ctrl_if.sv
// rtl/ddr_mem_ctrl_if.sv - core request/response and SRAM bus bundle for ddr_mem_ctrl
// slave is the controller's view; master is the core plus SRAM side.
interface ddr_mem_ctrl_if;
    logic         ddr_chip_enable;
    logic [18:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [63:0]  ddr_opstore_write_mask;
    logic [63:0]  ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic         ddr_operation_done;
    logic         ddr_ready;
    logic         mem_en;
    logic         mem_we;
    logic [18:0]  mem_addr;
    logic [63:0]  mem_wmask;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;

    modport slave (
        input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
        input  ddr_opstore_write_mask, ddr_opstore_write_data, mem_rdata,
        output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
        output ddr_opstore_write_mask, ddr_opstore_write_data, mem_rdata,
        input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/ddr_mem_ctrl.sv
// rtl/ddr_mem_ctrl.sv - single-request DDR latency model sequencing a 64b synchronous SRAM
// Handles single read, masked single write and 8-beat aligned burst read.
module ddr_mem_ctrl #(
    parameter int ACCESS_LATENCY = 4,
    parameter int LAT_CNT_WIDTH  = 4
) (
    input logic           clock,
    input logic           reset,
    ddr_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RDWAIT, S_DONE} state_t;

    state_t                   r_state;
    logic [LAT_CNT_WIDTH-1:0] r_cnt;
    logic [2:0]               r_beat;
    logic [18:0]              r_index;
    logic                     r_write;
    logic                     r_burst;
    logic [63:0]              r_mask;
    logic [63:0]              r_data;

    logic                     r_ready;
    logic                     r_done;
    logic                     r_mem_en;
    logic                     r_mem_we;
    logic [18:0]              r_mem_addr;
    logic [63:0]              r_mem_wmask;
    logic [63:0]              r_mem_wdata;
    logic [63:0]              r_rd_data;
    logic [511:0]             r_inst;

    logic                     w_accept;
    logic                     w_start;
    logic                     w_live;
    logic [18:0]              w_idx;
    logic                     w_burst;
    logic                     w_write;
    logic [63:0]              w_mask;
    logic [63:0]              w_data;
    logic [8:0]               w_slot;

    assign w_accept = (r_state == S_IDLE) && r_ready && bus.ddr_chip_enable;
    assign w_start  = (w_accept && (ACCESS_LATENCY == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == '0));

    // With zero latency the first access issues on the accept edge, before the capture registers load.
    assign w_live   = (r_state == S_IDLE);
    assign w_idx    = w_live ? bus.ddr_index : r_index;
    assign w_burst  = w_live ? bus.ddr_burst_mode : r_burst;
    assign w_write  = w_live ? (bus.ddr_write_enable & ~bus.ddr_burst_mode) : r_write;
    assign w_mask   = w_live ? bus.ddr_opstore_write_mask : r_mask;
    assign w_data   = w_live ? bus.ddr_opstore_write_data : r_data;

    // Slice of the beat whose read data is on mem_rdata this cycle.
    assign w_slot   = {r_beat - 3'd1, 6'd0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_index     <= '0;
            r_write     <= 1'b0;
            r_burst     <= 1'b0;
            r_mask      <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= '0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
            r_inst      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= '0;
            r_mem_wdata <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_index <= bus.ddr_index;
                        r_write <= bus.ddr_write_enable & ~bus.ddr_burst_mode;
                        r_burst <= bus.ddr_burst_mode;
                        r_mask  <= bus.ddr_opstore_write_mask;
                        r_data  <= bus.ddr_opstore_write_data;
                        r_ready <= 1'b0;
                        r_cnt   <= LAT_CNT_WIDTH'(ACCESS_LATENCY - 1);
                        r_state <= S_WAIT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (r_burst) begin
                        if (r_beat != 3'd0) begin
                            r_inst[w_slot +: 64] <= bus.mem_rdata;
                        end
                        if (r_beat == 3'd7) begin
                            r_state <= S_RDWAIT;
                        end else begin
                            r_beat     <= r_beat + 3'd1;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= {r_index[18:3], r_beat + 3'd1};
                        end
                    end else if (r_write) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (r_burst) begin
                        r_inst[511:448] <= bus.mem_rdata;
                    end else begin
                        r_rd_data <= bus.mem_rdata;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_start) begin
                r_state     <= S_ACCESS;
                r_beat      <= 3'd0;
                r_mem_en    <= 1'b1;
                r_mem_we    <= w_write;
                r_mem_addr  <= w_burst ? {w_idx[18:3], 3'b000} : w_idx;
                r_mem_wmask <= w_write ? w_mask : 64'd0;
                r_mem_wdata <= w_write ? w_data : 64'd0;
            end
        end
    end

    assign bus.ddr_ready            = r_ready;
    assign bus.ddr_operation_done   = r_done;
    assign bus.ddr_opload_read_data = r_rd_data;
    assign bus.ddr_pc_read_inst     = r_inst;
    assign bus.mem_en               = r_mem_en;
    assign bus.mem_we               = r_mem_we;
    assign bus.mem_addr             = r_mem_addr;
    assign bus.mem_wmask            = r_mem_wmask;
    assign bus.mem_wdata            = r_mem_wdata;
endmodule

// File: tb/tb_ddr_mem_ctrl.sv
// tb/tb_ddr_mem_ctrl.sv - directed vector bench for ddr_mem_ctrl at latency 4 and latency 0
module tb_ddr_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_mem_ctrl_if bus4();
    ddr_mem_ctrl_if bus0();

    ddr_mem_ctrl #(.ACCESS_LATENCY(4), .LAT_CNT_WIDTH(4)) dut4 (.clock(clk), .reset(rst), .bus(bus4));
    ddr_mem_ctrl #(.ACCESS_LATENCY(0), .LAT_CNT_WIDTH(4)) dut0 (.clock(clk), .reset(rst), .bus(bus0));

    logic [63:0] sram4 [logic [18:0]];
    logic [63:0] sram0 [logic [18:0]];

    function automatic logic [63:0] rd4(input logic [18:0] a);
        return sram4.exists(a) ? sram4[a] : 64'd0;
    endfunction

    function automatic logic [63:0] rd0(input logic [18:0] a);
        return sram0.exists(a) ? sram0[a] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (bus4.mem_en) begin
            if (bus4.mem_we)
                sram4[bus4.mem_addr] = (rd4(bus4.mem_addr) & ~bus4.mem_wmask) | (bus4.mem_wdata & bus4.mem_wmask);
            else
                bus4.mem_rdata <= rd4(bus4.mem_addr);
        end
        if (bus0.mem_en) begin
            if (bus0.mem_we)
                sram0[bus0.mem_addr] = (rd0(bus0.mem_addr) & ~bus0.mem_wmask) | (bus0.mem_wdata & bus0.mem_wmask);
            else
                bus0.mem_rdata <= rd0(bus0.mem_addr);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          lat;
    int          en_cnt;
    logic        we_seen;
    logic        ready_after;
    logic        done_after;
    logic [18:0] addr_q[$];
    int          en_at[$];

    task automatic run_req4(input logic [18:0] idx, input logic we, input logic bm,
                            input logic [63:0] mask, input logic [63:0] data);
        lat = -1;
        en_cnt = 0;
        we_seen = 1'b0;
        addr_q.delete();
        en_at.delete();
        @(negedge clk);
        bus4.ddr_chip_enable        = 1'b1;
        bus4.ddr_index              = idx;
        bus4.ddr_write_enable       = we;
        bus4.ddr_burst_mode         = bm;
        bus4.ddr_opstore_write_mask = mask;
        bus4.ddr_opstore_write_data = data;
        @(negedge clk);
        bus4.ddr_chip_enable        = 1'b0;
        bus4.ddr_index              = ~idx;
        bus4.ddr_opstore_write_data = ~data;
        for (int j = 0; j < 40 && lat < 0; j++) begin
            if (bus4.mem_en) begin
                en_cnt++;
                addr_q.push_back(bus4.mem_addr);
                en_at.push_back(j);
            end
            if (bus4.mem_we) we_seen = 1'b1;
            if (bus4.ddr_operation_done) lat = j;
            @(negedge clk);
        end
        ready_after = bus4.ddr_ready;
        done_after  = bus4.ddr_operation_done;
        while (addr_q.size() < 8) begin
            addr_q.push_back('x);
            en_at.push_back(-1);
        end
    endtask

    typedef struct {
        logic        we;
        logic [18:0] idx;
        logic [63:0] mask;
        logic [63:0] data;
        int          exp_lat;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] last_rd;
    int          n_en0;
    int          n_done0;
    int          done_at0;
    logic [18:0] en_addr0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Latency-4 intervals after the accept edge: access at 4, read done at 6, write done at 5.
        vecs[0] = '{1'b0, 19'h00010, 64'd0, 64'd0, 6, 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{1'b1, 19'h00020, 64'h0000_0000_FFFF_FFFF, 64'h1111_2222_3333_4444, 5, 64'd0};
        vecs[2] = '{1'b0, 19'h00020, 64'd0, 64'd0, 6, 64'hAAAA_AAAA_3333_4444};
        vecs[3] = '{1'b1, 19'h00021, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 5, 64'd0};
        vecs[4] = '{1'b0, 19'h00021, 64'd0, 64'd0, 6, 64'h0123_4567_89AB_CDEF};
        vecs[5] = '{1'b1, 19'h00022, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'd0};
        vecs[6] = '{1'b0, 19'h00022, 64'd0, 64'd0, 6, 64'h5555_5555_5555_5555};
        vecs[7] = '{1'b0, 19'h00030, 64'd0, 64'd0, 6, 64'd0};
        vecs[8] = '{1'b1, 19'h00031, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'd0};
        vecs[9] = '{1'b0, 19'h00031, 64'd0, 64'd0, 6, 64'hF0F0_F0F0_F0F0_F0F0};

        sram4[19'h00010] = 64'hDEAD_BEEF_0123_4567;
        for (int k = 1; k < 8; k++) sram4[19'(16 + k)] = 64'(k + 1);
        sram4[19'h00020] = 64'hAAAA_AAAA_BBBB_BBBB;
        sram4[19'h00022] = 64'h5555_5555_5555_5555;
        for (int k = 0; k < 8; k++) sram4[19'(32'h7FFF8 + k)] = 64'(256 + k);
        sram0[19'h00005] = 64'hCAFE_F00D_1234_5678;
        sram0[19'h00006] = 64'h0BAD_0BAD_0BAD_0BAD;

        bus4.ddr_chip_enable = 1'b0; bus4.ddr_index = '0; bus4.ddr_write_enable = 1'b0;
        bus4.ddr_burst_mode = 1'b0; bus4.ddr_opstore_write_mask = '0; bus4.ddr_opstore_write_data = '0;
        bus0.ddr_chip_enable = 1'b0; bus0.ddr_index = '0; bus0.ddr_write_enable = 1'b0;
        bus0.ddr_burst_mode = 1'b0; bus0.ddr_opstore_write_mask = '0; bus0.ddr_opstore_write_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  512'(bus4.ddr_ready), 512'(0));
        check("rst_done",   512'(bus4.ddr_operation_done), 512'(0));
        check("rst_mem_en", 512'(bus4.mem_en), 512'(0));
        check("rst_rdata",  512'(bus4.ddr_opload_read_data), 512'(0));
        check("rst_inst",   bus4.ddr_pc_read_inst, 512'(0));
        rst = 1'b0;
        #1;
        check("rel_ready_low", 512'(bus4.ddr_ready), 512'(0));
        @(negedge clk);
        check("rel_ready_high", 512'(bus4.ddr_ready), 512'(1));
        check("rel_ready_high_l0", 512'(bus0.ddr_ready), 512'(1));

        last_rd = 64'd0;
        for (int v = 0; v < 10; v++) begin
            run_req4(vecs[v].idx, vecs[v].we, 1'b0, vecs[v].mask, vecs[v].data);
            if (!vecs[v].we) last_rd = vecs[v].exp_rd;
            check($sformatf("v%0d_latency", v), 512'(lat), 512'(vecs[v].exp_lat));
            check($sformatf("v%0d_en_count", v), 512'(en_cnt), 512'(1));
            check($sformatf("v%0d_en_cycle", v), 512'(en_at[0]), 512'(4));
            check($sformatf("v%0d_addr", v), 512'(addr_q[0]), 512'(vecs[v].idx));
            check($sformatf("v%0d_we", v), 512'(we_seen), 512'(vecs[v].we));
            check($sformatf("v%0d_ready_after", v), 512'(ready_after), 512'(1));
            check($sformatf("v%0d_done_once", v), 512'(done_after), 512'(0));
            check($sformatf("v%0d_rdata", v), 512'(bus4.ddr_opload_read_data), 512'(last_rd));
        end

        // Burst from a mid-block index reads the whole aligned block.
        sram4[19'h00010] = 64'd1;
        run_req4(19'h00013, 1'b0, 1'b1, 64'd0, 64'd0);
        check("burst_latency", 512'(lat), 512'(13));
        check("burst_en_count", 512'(en_cnt), 512'(8));
        check("burst_no_we", 512'(we_seen), 512'(0));
        check("burst_rdata_kept", 512'(bus4.ddr_opload_read_data), 512'(64'hF0F0_F0F0_F0F0_F0F0));
        for (int k = 0; k < 8; k++) begin
            check($sformatf("burst_addr%0d", k), 512'(addr_q[k]), 512'(19'(16 + k)));
            check($sformatf("burst_cyc%0d", k), 512'(en_at[k]), 512'(4 + k));
            check($sformatf("burst_beat%0d", k), 512'(bus4.ddr_pc_read_inst[64*k +: 64]), 512'(k + 1));
        end

        // Burst with write_enable at the top of the address space.
        run_req4(19'h7FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("top_latency", 512'(lat), 512'(13));
        check("top_no_we", 512'(we_seen), 512'(0));
        check("top_sram_intact", 512'(rd4(19'h7FFFF)), 512'(64'd263));
        for (int k = 0; k < 8; k++) begin
            check($sformatf("top_addr%0d", k), 512'(addr_q[k]), 512'(19'(32'h7FFF8 + k)));
            check($sformatf("top_beat%0d", k), 512'(bus4.ddr_pc_read_inst[64*k +: 64]), 512'(256 + k));
        end

        // Zero latency, with a second strobe while busy that must be dropped.
        n_en0 = 0; n_done0 = 0; done_at0 = -1; en_addr0 = 'x;
        @(negedge clk);
        bus0.ddr_chip_enable = 1'b1;
        bus0.ddr_index       = 19'h00005;
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            if (bus0.mem_en) begin
                n_en0++;
                if (n_en0 == 1) en_addr0 = bus0.mem_addr;
            end
            if (bus0.ddr_operation_done) begin
                n_done0++;
                if (done_at0 < 0) done_at0 = j;
            end
            if (j == 0) begin
                check("l0_en_first_cycle", 512'(bus0.mem_en), 512'(1));
                bus0.ddr_index = 19'h00006;
            end
            if (j == 1) bus0.ddr_chip_enable = 1'b0;
            @(negedge clk);
        end
        check("l0_done_at", 512'(done_at0), 512'(2));
        check("l0_done_count", 512'(n_done0), 512'(1));
        check("l0_en_count", 512'(n_en0), 512'(1));
        check("l0_addr", 512'(en_addr0), 512'(19'h00005));
        check("l0_rdata", 512'(bus0.ddr_opload_read_data), 512'(64'hCAFE_F00D_1234_5678));

        // Reset in the middle of a burst.
        @(negedge clk);
        bus4.ddr_chip_enable = 1'b1;
        bus4.ddr_index       = 19'h00010;
        bus4.ddr_burst_mode  = 1'b1;
        bus4.ddr_write_enable = 1'b0;
        @(negedge clk);
        bus4.ddr_chip_enable = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_en", 512'(bus4.mem_en), 512'(1));
        check("mid_addr", 512'(bus4.mem_addr), 512'(19'h00013));
        check("mid_beat0", 512'(bus4.ddr_pc_read_inst[63:0]), 512'(1));
        check("mid_beat2_old", 512'(bus4.ddr_pc_read_inst[191:128]), 512'(258));
        rst = 1'b1;
        #1;
        check("abort_en", 512'(bus4.mem_en), 512'(0));
        check("abort_addr", 512'(bus4.mem_addr), 512'(0));
        check("abort_ready", 512'(bus4.ddr_ready), 512'(0));
        check("abort_done", 512'(bus4.ddr_operation_done), 512'(0));
        check("abort_rdata", 512'(bus4.ddr_opload_read_data), 512'(0));
        check("abort_inst", bus4.ddr_pc_read_inst, 512'(0));
        @(posedge clk);
        #1;
        check("abort_hold_done", 512'(bus4.ddr_operation_done), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        bus4.ddr_burst_mode = 1'b0;
        #1;
        check("abort_rel_ready_low", 512'(bus4.ddr_ready), 512'(0));
        @(negedge clk);
        check("abort_rel_ready_high", 512'(bus4.ddr_ready), 512'(1));
        check("abort_rel_no_done", 512'(bus4.ddr_operation_done), 512'(0));

        run_req4(19'h00010, 1'b0, 1'b0, 64'd0, 64'd0);
        check("post_latency", 512'(lat), 512'(6));
        check("post_rdata", 512'(bus4.ddr_opload_read_data), 512'(1));
        check("post_inst_clear", bus4.ddr_pc_read_inst, 512'(0));
        check("post_ready", 512'(ready_after), 512'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
